// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional opcode legality check enabled by defining ALU_OPCHECK_EN.
module alu_req_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_src1,
   input  logic [DATA_WIDTH-1:0] req0_src2,
   input  logic [3:0]            req0_op,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_src1,
   input  logic [DATA_WIDTH-1:0] req1_src2,
   input  logic [3:0]            req1_op,
   output logic [DATA_WIDTH-1:0] alu_src1,
   output logic [DATA_WIDTH-1:0] alu_src2,
   output logic [3:0]            alu_control,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t state;
   state_t state_next;
   logic   last_grant;
   logic   grant_valid;
   logic   grant_id;

`ifdef ALU_OPCHECK_EN
   function automatic logic op_illegal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_illegal = 1'b0;
         default:                                              op_illegal = 1'b1;
      endcase
   endfunction
`endif

   // Winner selection: a lone valid always wins, a tie goes to the requester not served last.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = ~last_grant;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end else begin
         grant_valid = 1'b0;
         grant_id    = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_valid) state_next = EXEC;
            else             state_next = IDLE;
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_valid && rsp_ready) state_next = IDLE;
            else                        state_next = RESP;
         end
         default: state_next = IDLE;
      endcase
   end

   // Ready outputs: only in IDLE, only for the winner, never during reset.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && (state == IDLE) && grant_valid) begin
         req0_ready = ~grant_id;
         req1_ready = grant_id;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   // Operand latch, grant history and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant  <= 1'b1;
         alu_src1    <= '0;
         alu_src2    <= '0;
         alu_control <= 4'b0000;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
`ifdef ALU_OPCHECK_EN
         rsp_err     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  alu_src1    <= grant_id ? req1_src1 : req0_src1;
                  alu_src2    <= grant_id ? req1_src2 : req0_src2;
                  alu_control <= grant_id ? req1_op   : req0_op;
                  rsp_id      <= grant_id;
                  last_grant  <= grant_id;
               end
            end
            EXEC: begin
               rsp_valid <= 1'b1;
`ifdef ALU_OPCHECK_EN
               if (op_illegal(alu_control)) begin
                  rsp_result <= '0;
                  rsp_zero   <= 1'b0;
                  rsp_err    <= 1'b1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  rsp_err    <= 1'b0;
               end
`else
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
`endif
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: begin
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifndef ALU_OPCHECK_EN
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: vector table plus backpressure,
// mid-operation reset and round-robin alternation sequences.
module tb_alu_req_arbiter;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
   logic [3:0]    req0_op, req1_op;
   logic [W-1:0]  alu_src1, alu_src2, alu_result;
   logic [3:0]    alu_control;
   logic          alu_zero;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [W-1:0]  rsp_result;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_op(req1_op),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   // External ALU stand-in; undefined opcodes return a recognisable pattern.
   always_comb begin
      case (alu_control)
         4'b0000: alu_result = alu_src1 & alu_src2;
         4'b0001: alu_result = alu_src1 | alu_src2;
         4'b0010: alu_result = alu_src1 + alu_src2;
         4'b0110: alu_result = alu_src1 - alu_src2;
         4'b0111: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
         4'b1100: alu_result = ~(alu_src1 | alu_src2);
         default: alu_result = 32'hDEADBEEF;
      endcase
      alu_zero = (alu_src1 == alu_src2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        v0;
      logic [31:0] a0, b0;
      logic [3:0]  op0;
      logic        v1;
      logic [31:0] a1, b1;
      logic [3:0]  op1;
      logic        id;
      logic [31:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t vt [8];

   initial begin
      int got;
      int first_c;

      vt[0] = '{1'b1, 32'd5, 32'd3, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000,
                1'b0, 32'd8, 1'b0, 1'b0};
      vt[1] = '{1'b1, 32'd7, 32'd7, 4'b0110, 1'b1, 32'hF0, 32'h0F, 4'b0001,
                1'b1, 32'hFF, 1'b0, 1'b0};
      vt[2] = '{1'b1, 32'd7, 32'd7, 4'b0110, 1'b1, 32'hF0, 32'h0F, 4'b0001,
                1'b0, 32'd0, 1'b1, 1'b0};
      vt[3] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0000,
                1'b1, 32'h0F000F00, 1'b0, 1'b0};
      vt[4] = '{1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd2, 32'd9, 4'b0111,
                1'b1, 32'd1, 1'b0, 1'b0};
      vt[5] = '{1'b1, 32'd0, 32'd0, 4'b1100, 1'b0, 32'd0, 32'd0, 4'b0000,
                1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
`ifdef ALU_OPCHECK_EN
      vt[6] = '{1'b1, 32'd4, 32'd5, 4'b0011, 1'b0, 32'd0, 32'd0, 4'b0000,
                1'b0, 32'd0, 1'b0, 1'b1};
`else
      vt[6] = '{1'b1, 32'd4, 32'd5, 4'b0011, 1'b0, 32'd0, 32'd0, 4'b0000,
                1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
`endif
      vt[7] = '{1'b1, 32'd9, 32'd2, 4'b0111, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0010,
                1'b1, 32'd0, 1'b0, 1'b0};

      // Reset with both requesters valid: nothing may be granted.
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd2; req0_op = 4'b0010;
      req1_valid = 1'b1; req1_src1 = 32'd3; req1_src2 = 32'd4; req1_op = 4'b0010;
      repeat (2) @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_alu_src1", alu_src1, 32'd0);
      chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req0_valid = vt[i].v0; req0_src1 = vt[i].a0; req0_src2 = vt[i].b0; req0_op = vt[i].op0;
         req1_valid = vt[i].v1; req1_src1 = vt[i].a1; req1_src2 = vt[i].b1; req1_op = vt[i].op1;
         rsp_ready = 1'b0;
         #1;
         chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, ~vt[i].id});
         chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vt[i].id});
         @(negedge clk);
         req0_valid = 1'b0; req1_valid = 1'b0;
         chk($sformatf("v%0d_alu_src1", i), alu_src1, vt[i].id ? vt[i].a1 : vt[i].a0);
         chk($sformatf("v%0d_alu_src2", i), alu_src2, vt[i].id ? vt[i].b1 : vt[i].b0);
         chk($sformatf("v%0d_alu_control", i), {28'd0, alu_control},
             {28'd0, vt[i].id ? vt[i].op1 : vt[i].op0});
         chk($sformatf("v%0d_exec_valid", i), {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("v%0d_rsp_id", i), {31'd0, rsp_id}, {31'd0, vt[i].id});
         chk($sformatf("v%0d_rsp_result", i), rsp_result, vt[i].res);
         chk($sformatf("v%0d_rsp_zero", i), {31'd0, rsp_zero}, {31'd0, vt[i].zero});
         chk($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vt[i].err});
         rsp_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_rsp_drop", i), {31'd0, rsp_valid}, 32'd0);
         rsp_ready = 1'b0;
      end

      // Backpressure: response held for 5 cycles while req1 waits.
      @(negedge clk);
      req0_valid = 1'b1; req0_src1 = 32'd10; req0_src2 = 32'd20; req0_op = 4'b0010;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_src1 = 32'd50; req1_src2 = 32'd8; req1_op = 4'b0110;
      #1;
      chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp%0d_id", k), {31'd0, rsp_id}, 32'd0);
         chk($sformatf("bp%0d_result", k), rsp_result, 32'd30);
         chk($sformatf("bp%0d_ready1", k), {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("bp_drop_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
      req1_valid = 1'b0;
      chk("bp_req1_op", {28'd0, alu_control}, 32'd6);
      chk("bp_req1_src1", alu_src1, 32'd50);
      @(negedge clk);
      chk("bp_req1_id", {31'd0, rsp_id}, 32'd1);
      chk("bp_req1_result", rsp_result, 32'd42);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset during EXEC of a req1 NOR aborts it; afterwards req0 wins first.
      @(negedge clk);
      req1_valid = 1'b1; req1_src1 = 32'd3; req1_src2 = 32'd4; req1_op = 4'b1100;
      @(negedge clk);
      chk("mr_exec_control", {28'd0, alu_control}, 32'd12);
      rst = 1'b1;
      req0_valid = 1'b1; req0_src1 = 32'd7; req0_src2 = 32'd7; req0_op = 4'b0110;
      req1_src1 = 32'hF0; req1_src2 = 32'h0F; req1_op = 4'b0001;
      #1;
      chk("mr_alu_src1", alu_src1, 32'd0);
      chk("mr_alu_src2", alu_src2, 32'd0);
      chk("mr_alu_control", {28'd0, alu_control}, 32'd0);
      chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mr_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("mr_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("mr_ready0", {31'd0, req0_ready}, 32'd0);
      chk("mr_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("mr_post_ready0", {31'd0, req0_ready}, 32'd1);
      chk("mr_post_ready1", {31'd0, req1_ready}, 32'd0);

      // Both requesters held valid: responses alternate 0,1,0,1 every 3 cycles.
      got = 0;
      first_c = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            if (got == 0) first_c = c;
            chk($sformatf("rr%0d_cycle", got), c, first_c + 3 * got);
            chk($sformatf("rr%0d_id", got), {31'd0, rsp_id}, (got % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("rr%0d_result", got), rsp_result, (got % 2 == 0) ? 32'd0 : 32'hFF);
            chk($sformatf("rr%0d_zero", got), {31'd0, rsp_zero}, (got % 2 == 0) ? 32'd1 : 32'd0);
            got++;
         end
      end
      chk("rr_count", got, 32'd4);
      chk("rr_first_cycle", first_c, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
